bpred_resolve: RTL and testbench

In-flight branch tracking and resolution stage that sits directly downstream of the perceptron predictor. It records every fetch-time prediction in an in-order queue. When execute resolves a branch, it compares the actual outcome against the oldest entry. It then drives the predictor's update, miss, GHR-recovery and RAS-repair inputs, and flushes wrong-path entries.

---
 rtl/bpred_pkg.sv | 20 ++
 rtl/bres_fifo.sv | 68 ++++++
 rtl/bpred_resolve.sv | 166 ++++++++++++++++
 tb/tb_bpred_resolve.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types for the branch resolution stage: queue entry layout and FSM states.
package bpred_pkg;

    localparam int unsigned BP_GHR_SIZE = 12;

    typedef struct packed {
        logic [31:0]            PC;
        logic                   p_dir;
        logic [31:0]            p_target;
        logic [BP_GHR_SIZE-1:0] ghr;
        logic                   isCall;
        logic                   isRet;
    } bres_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bres_state_e;

endpackage

// File: rtl/bres_fifo.sv
// In-order queue of in-flight branch predictions with async reset and single-cycle flush.
module bres_fifo
    import bpred_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  bres_entry_t              din,
    output bres_entry_t              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    bres_entry_t     mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[head_q];

    // A pop in the same cycle frees the head slot, so a full queue can still take a push.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + AW'(1);
            if (do_pop)  head_d = head_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= din;
    end

endmodule

// File: rtl/bpred_resolve.sv
// Branch resolution: compares execute outcomes with queued predictions and drives predictor
// update/recovery. Optional saturating statistics counters under `BRES_STATS_EN.
module bpred_resolve
    import bpred_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned GHR_SIZE = BP_GHR_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_push,
    input  logic [31:0]         fetch_PC,
    input  logic                fetch_p_dir,
    input  logic [31:0]         fetch_p_target,
    input  logic [GHR_SIZE-1:0] fetch_ghr,
    input  logic                fetch_isCall,
    input  logic                fetch_isRet,
    output logic                bres_full,
    input  logic                exe_resolve,
    input  logic                exe_dir,
    input  logic [31:0]         exe_target,
    output logic                execute_bpredictor_update,
    output logic [31:0]         execute_bpredictor_PC4,
    output logic [31:0]         execute_bpredictor_target,
    output logic                execute_bpredictor_dir,
    output logic                execute_bpredictor_miss,
    output logic                execute_missPred,
    output logic                execute_isCall,
    output logic                execute_c_r_after_r,
    output logic [GHR_SIZE-1:0] recover_ghr,
    output logic                bres_err
`ifdef BRES_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_miss,
    output logic [31:0]         stat_missPred
`endif
);

    bres_state_e          state_q, state_d;
    bres_entry_t          fetch_entry, head;
    logic                 q_empty;
    logic [$clog2(DEPTH):0] q_count;
    logic                 resolve_ok, miss, miss_pred, flush;

    logic                 update_q, update_d, miss_q, miss_d, missp_q, missp_d;
    logic                 is_call_q, is_call_d, crr_q, crr_d, dir_q, dir_d;
    logic                 last_was_ret_q, last_was_ret_d, err_q, err_d;
    logic [31:0]          pc4_q, pc4_d, target_q, target_d;
    logic [GHR_SIZE-1:0]  ghr_q, ghr_d;

    assign fetch_entry = '{PC: fetch_PC, p_dir: fetch_p_dir, p_target: fetch_p_target,
                           ghr: fetch_ghr, isCall: fetch_isCall, isRet: fetch_isRet};

    assign resolve_ok = exe_resolve & ~q_empty & (state_q == RUN);
    assign miss       = exe_dir != head.p_dir;
    assign miss_pred  = miss | (exe_dir & (exe_target != head.p_target));
    assign flush      = resolve_ok & miss_pred;

    bres_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (fetch_push & (state_q == RUN)),
        .pop   (resolve_ok),
        .flush (flush),
        .din   (fetch_entry),
        .dout  (head),
        .full  (bres_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_comb begin
        state_d        = RUN;
        update_d       = resolve_ok;
        miss_d         = resolve_ok & miss;
        missp_d        = resolve_ok & miss_pred;
        is_call_d      = resolve_ok & head.isCall;
        crr_d          = resolve_ok & (head.isCall | head.isRet) & last_was_ret_q;
        pc4_d          = pc4_q;
        target_d       = target_q;
        dir_d          = dir_q;
        ghr_d          = ghr_q;
        last_was_ret_d = last_was_ret_q;
        err_d          = err_q | (exe_resolve & ~resolve_ok);
        if (state_q == RUN && flush) state_d = RECOVER;
        if (resolve_ok) begin
            pc4_d          = head.PC + 32'd4;
            target_d       = exe_target;
            dir_d          = exe_dir;
            ghr_d          = {exe_dir, head.ghr[GHR_SIZE-1:1]};
            last_was_ret_d = head.isRet;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            update_q       <= 1'b0;
            miss_q         <= 1'b0;
            missp_q        <= 1'b0;
            is_call_q      <= 1'b0;
            crr_q          <= 1'b0;
            pc4_q          <= '0;
            target_q       <= '0;
            dir_q          <= 1'b0;
            ghr_q          <= '0;
            last_was_ret_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            update_q       <= update_d;
            miss_q         <= miss_d;
            missp_q        <= missp_d;
            is_call_q      <= is_call_d;
            crr_q          <= crr_d;
            pc4_q          <= pc4_d;
            target_q       <= target_d;
            dir_q          <= dir_d;
            ghr_q          <= ghr_d;
            last_was_ret_q <= last_was_ret_d;
            err_q          <= err_d;
        end
    end

    assign execute_bpredictor_update = update_q;
    assign execute_bpredictor_PC4    = pc4_q;
    assign execute_bpredictor_target = target_q;
    assign execute_bpredictor_dir    = dir_q;
    assign execute_bpredictor_miss   = miss_q;
    assign execute_missPred          = missp_q;
    assign execute_isCall            = is_call_q;
    assign execute_c_r_after_r       = crr_q;
    assign recover_ghr               = ghr_q;
    assign bres_err                  = err_q;

`ifdef BRES_STATS_EN
    logic [31:0] st_br_q, st_br_d, st_miss_q, st_miss_d, st_mp_q, st_mp_d;

    always_comb begin
        st_br_d   = st_br_q;
        st_miss_d = st_miss_q;
        st_mp_d   = st_mp_q;
        if (resolve_ok && st_br_q != '1)               st_br_d   = st_br_q + 32'd1;
        if (resolve_ok && miss && st_miss_q != '1)     st_miss_d = st_miss_q + 32'd1;
        if (resolve_ok && miss_pred && st_mp_q != '1)  st_mp_d   = st_mp_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_br_q   <= '0;
            st_miss_q <= '0;
            st_mp_q   <= '0;
        end else begin
            st_br_q   <= st_br_d;
            st_miss_q <= st_miss_d;
            st_mp_q   <= st_mp_d;
        end
    end

    assign stat_branches = st_br_q;
    assign stat_miss     = st_miss_q;
    assign stat_missPred = st_mp_q;
`endif

endmodule

// File: tb/tb_bpred_resolve.sv
// Directed self-checking bench for bpred_resolve.
module tb_bpred_resolve;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_push = 1'b0;
    logic [31:0] fetch_PC = '0;
    logic        fetch_p_dir = 1'b0;
    logic [31:0] fetch_p_target = '0;
    logic [11:0] fetch_ghr = '0;
    logic        fetch_isCall = 1'b0;
    logic        fetch_isRet = 1'b0;
    logic        exe_resolve = 1'b0;
    logic        exe_dir = 1'b0;
    logic [31:0] exe_target = '0;
    logic        bres_full, upd, dir_o, miss_o, missp_o, is_call_o, crr_o, bres_err;
    logic [31:0] pc4_o, tgt_o;
    logic [11:0] rghr;
`ifdef BRES_STATS_EN
    logic [31:0] stat_branches, stat_miss, stat_missPred;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bpred_resolve #(.DEPTH(8), .GHR_SIZE(12)) dut (
        .clk(clk), .reset(reset),
        .fetch_push(fetch_push), .fetch_PC(fetch_PC), .fetch_p_dir(fetch_p_dir),
        .fetch_p_target(fetch_p_target), .fetch_ghr(fetch_ghr),
        .fetch_isCall(fetch_isCall), .fetch_isRet(fetch_isRet),
        .bres_full(bres_full),
        .exe_resolve(exe_resolve), .exe_dir(exe_dir), .exe_target(exe_target),
        .execute_bpredictor_update(upd), .execute_bpredictor_PC4(pc4_o),
        .execute_bpredictor_target(tgt_o), .execute_bpredictor_dir(dir_o),
        .execute_bpredictor_miss(miss_o), .execute_missPred(missp_o),
        .execute_isCall(is_call_o), .execute_c_r_after_r(crr_o),
        .recover_ghr(rghr), .bres_err(bres_err)
`ifdef BRES_STATS_EN
        , .stat_branches(stat_branches), .stat_miss(stat_miss), .stat_missPred(stat_missPred)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic d, input logic [31:0] t,
                            input logic [11:0] g, input logic c, input logic r);
        fetch_push = 1'b1; fetch_PC = pc; fetch_p_dir = d; fetch_p_target = t;
        fetch_ghr = g; fetch_isCall = c; fetch_isRet = r;
    endtask

    task automatic set_resolve(input logic d, input logic [31:0] t);
        exe_resolve = 1'b1; exe_dir = d; exe_target = t;
    endtask

    task automatic clear_inputs();
        fetch_push = 1'b0; exe_resolve = 1'b0;
        fetch_isCall = 1'b0; fetch_isRet = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (upd !== 1'b0) $display("FAIL rst_update got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (pc4_o !== 32'h0) $display("FAIL rst_pc4 got %0h exp 0", pc4_o); else pass_cnt++;
        total_cnt++; if (rghr !== 12'h0) $display("FAIL rst_ghr got %0h exp 0", rghr); else pass_cnt++;
        total_cnt++; if (bres_full !== 1'b0) $display("FAIL rst_full got %0h exp 0", bres_full); else pass_cnt++;
        total_cnt++; if (bres_err !== 1'b0) $display("FAIL rst_err got %0h exp 0", bres_err); else pass_cnt++;
        total_cnt++; if ({missp_o, miss_o, crr_o, is_call_o} !== 4'b0) $display("FAIL rst_pulses got %0h exp 0", {missp_o, miss_o, crr_o, is_call_o}); else pass_cnt++;
    endtask

    task automatic test_hit();
        do_reset();
        set_push(32'h40, 1'b1, 32'h80, 12'h0, 1'b0, 1'b0);
        tick(); clear_inputs();
        set_resolve(1'b1, 32'h80);
        tick(); clear_inputs();
        total_cnt++; if (upd !== 1'b1) $display("FAIL hit_update got %0h exp 1", upd); else pass_cnt++;
        total_cnt++; if (miss_o !== 1'b0) $display("FAIL hit_miss got %0h exp 0", miss_o); else pass_cnt++;
        total_cnt++; if (missp_o !== 1'b0) $display("FAIL hit_misspred got %0h exp 0", missp_o); else pass_cnt++;
        total_cnt++; if (pc4_o !== 32'h44) $display("FAIL hit_pc4 got %0h exp 44", pc4_o); else pass_cnt++;
        total_cnt++; if (tgt_o !== 32'h80) $display("FAIL hit_target got %0h exp 80", tgt_o); else pass_cnt++;
        total_cnt++; if (dir_o !== 1'b1) $display("FAIL hit_dir got %0h exp 1", dir_o); else pass_cnt++;
        tick();
        total_cnt++; if (upd !== 1'b0) $display("FAIL hit_update_drop got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (pc4_o !== 32'h44) $display("FAIL hit_pc4_hold got %0h exp 44", pc4_o); else pass_cnt++;
    endtask

    task automatic test_dir_miss();
        do_reset();
        set_push(32'h40, 1'b0, 32'h80, 12'h0F3, 1'b0, 1'b0);
        tick(); clear_inputs();
        set_resolve(1'b1, 32'h100);
        tick(); clear_inputs();
        total_cnt++; if (miss_o !== 1'b1) $display("FAIL dmiss_miss got %0h exp 1", miss_o); else pass_cnt++;
        total_cnt++; if (missp_o !== 1'b1) $display("FAIL dmiss_misspred got %0h exp 1", missp_o); else pass_cnt++;
        total_cnt++; if (rghr !== 12'h879) $display("FAIL dmiss_ghr got %0h exp 879", rghr); else pass_cnt++;
        total_cnt++; if (bres_err !== 1'b0) $display("FAIL dmiss_err got %0h exp 0", bres_err); else pass_cnt++;
        set_push(32'h200, 1'b1, 32'h80, 12'h0, 1'b0, 1'b0);
        tick(); clear_inputs();
        total_cnt++; if (upd !== 1'b0) $display("FAIL dmiss_recover_update got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (rghr !== 12'h879) $display("FAIL dmiss_ghr_hold got %0h exp 879", rghr); else pass_cnt++;
        set_resolve(1'b1, 32'h80);
        tick(); clear_inputs();
        total_cnt++; if (upd !== 1'b0) $display("FAIL dmiss_push_dropped_update got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (bres_err !== 1'b1) $display("FAIL dmiss_push_dropped_err got %0h exp 1", bres_err); else pass_cnt++;
    endtask

    task automatic test_target_miss();
        do_reset();
        set_push(32'h40, 1'b1, 32'h80, 12'h0, 1'b0, 1'b0);
        tick();
        set_push(32'h50, 1'b0, 32'h0, 12'h0, 1'b0, 1'b0);
        tick(); clear_inputs();
        set_resolve(1'b1, 32'h90);
        tick(); clear_inputs();
        total_cnt++; if (miss_o !== 1'b0) $display("FAIL tmiss_miss got %0h exp 0", miss_o); else pass_cnt++;
        total_cnt++; if (missp_o !== 1'b1) $display("FAIL tmiss_misspred got %0h exp 1", missp_o); else pass_cnt++;
        total_cnt++; if (tgt_o !== 32'h90) $display("FAIL tmiss_target got %0h exp 90", tgt_o); else pass_cnt++;
        tick();
        set_resolve(1'b0, 32'h0);
        tick(); clear_inputs();
        total_cnt++; if (upd !== 1'b0) $display("FAIL tmiss_flushed_update got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (bres_err !== 1'b1) $display("FAIL tmiss_flushed_err got %0h exp 1", bres_err); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [31:0] exp_pc4;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_push(32'h100 + 32'(i) * 4, 1'b0, 32'h0, 12'h0, 1'b0, 1'b0);
            tick(); clear_inputs();
            if (i == 6) begin
                total_cnt++; if (bres_full !== 1'b0) $display("FAIL full_at7 got %0h exp 0", bres_full); else pass_cnt++;
            end
        end
        total_cnt++; if (bres_full !== 1'b1) $display("FAIL full_at8 got %0h exp 1", bres_full); else pass_cnt++;
        set_push(32'h999, 1'b0, 32'h0, 12'h0, 1'b0, 1'b0);
        tick(); clear_inputs();
        total_cnt++; if (bres_full !== 1'b1) $display("FAIL full_after_drop got %0h exp 1", bres_full); else pass_cnt++;
        set_push(32'h300, 1'b0, 32'h0, 12'h0, 1'b0, 1'b0);
        set_resolve(1'b0, 32'h0);
        tick(); clear_inputs();
        total_cnt++; if (upd !== 1'b1) $display("FAIL full_bb_update got %0h exp 1", upd); else pass_cnt++;
        total_cnt++; if (pc4_o !== 32'h104) $display("FAIL full_bb_pc4 got %0h exp 104", pc4_o); else pass_cnt++;
        total_cnt++; if (bres_full !== 1'b1) $display("FAIL full_bb_count8 got %0h exp 1", bres_full); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            exp_pc4 = (k == 7) ? 32'h304 : 32'h108 + 32'(k) * 4;
            set_resolve(1'b0, 32'h0);
            tick(); clear_inputs();
            total_cnt++; if (pc4_o !== exp_pc4) $display("FAIL full_drain_pc4[%0d] got %0h exp %0h", k, pc4_o, exp_pc4); else pass_cnt++;
            if (k == 0) begin
                total_cnt++; if (bres_full !== 1'b0) $display("FAIL full_after_pop got %0h exp 0", bres_full); else pass_cnt++;
            end
        end
        total_cnt++; if (bres_err !== 1'b0) $display("FAIL full_drain_err got %0h exp 0", bres_err); else pass_cnt++;
    endtask

    task automatic test_err_reset();
        do_reset();
        set_resolve(1'b1, 32'h0);
        tick(); clear_inputs();
        total_cnt++; if (upd !== 1'b0) $display("FAIL err_update got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (bres_err !== 1'b1) $display("FAIL err_set got %0h exp 1", bres_err); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            set_push(32'h500 + 32'(i) * 4, 1'b0, 32'h0, 12'h0, 1'b0, 1'b0);
            tick(); clear_inputs();
        end
        total_cnt++; if (bres_err !== 1'b1) $display("FAIL err_sticky got %0h exp 1", bres_err); else pass_cnt++;
        set_resolve(1'b0, 32'h0);
        tick(); clear_inputs();
        total_cnt++; if (pc4_o !== 32'h504) $display("FAIL err_pre_reset_pc4 got %0h exp 504", pc4_o); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bres_full !== 1'b0) $display("FAIL async_rst_full got %0h exp 0", bres_full); else pass_cnt++;
        total_cnt++; if (upd !== 1'b0) $display("FAIL async_rst_update got %0h exp 0", upd); else pass_cnt++;
        total_cnt++; if (pc4_o !== 32'h0) $display("FAIL async_rst_pc4 got %0h exp 0", pc4_o); else pass_cnt++;
        total_cnt++; if (bres_err !== 1'b0) $display("FAIL async_rst_err got %0h exp 0", bres_err); else pass_cnt++;
        #1 reset = 1'b0;
        set_resolve(1'b0, 32'h0);
        tick(); clear_inputs();
        total_cnt++; if (bres_err !== 1'b1) $display("FAIL async_rst_empty got %0h exp 1", bres_err); else pass_cnt++;
    endtask

    task automatic test_call_ret();
        do_reset();
        set_push(32'h60, 1'b1, 32'h70, 12'h0, 1'b0, 1'b1);
        tick();
        set_push(32'h64, 1'b1, 32'h90, 12'h0, 1'b1, 1'b0);
        tick(); clear_inputs();
        set_resolve(1'b1, 32'h70);
        tick(); clear_inputs();
        total_cnt++; if (crr_o !== 1'b0) $display("FAIL ret_crr got %0h exp 0", crr_o); else pass_cnt++;
        total_cnt++; if (is_call_o !== 1'b0) $display("FAIL ret_iscall got %0h exp 0", is_call_o); else pass_cnt++;
        set_resolve(1'b1, 32'h90);
        tick(); clear_inputs();
        total_cnt++; if (crr_o !== 1'b1) $display("FAIL call_crr got %0h exp 1", crr_o); else pass_cnt++;
        total_cnt++; if (is_call_o !== 1'b1) $display("FAIL call_iscall got %0h exp 1", is_call_o); else pass_cnt++;
        total_cnt++; if (pc4_o !== 32'h68) $display("FAIL call_pc4 got %0h exp 68", pc4_o); else pass_cnt++;
        tick();
        total_cnt++; if ({crr_o, is_call_o} !== 2'b00) $display("FAIL call_pulse_end got %0h exp 0", {crr_o, is_call_o}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_dir_miss();
        test_target_miss();
        test_full();
        test_err_reset();
        test_call_ret();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
